wr_ddr_pack_fifo: RTL and testbench

WR_DDR_PACK_FIFO -- requirements
Module: wr_ddr_pack_fifo

---
 rtl/wr_ddr_pack_fifo.sv | 176 +++++++++++++++++
 tb/tb_wr_ddr_pack_fifo.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_ddr_pack_fifo.sv
// ---------------------------------------------------------------------------
// wr_ddr_pack_fifo
//
// Width-converting FIFO that packs RATIO narrow write words into one wide
// read word (little-endian: the first write after a commit lands in lane 0).
// A packed word is committed to the memory when its last lane is written, or
// early on flush (unwritten lanes read as zero). Reads return committed words
// only, with one cycle of latency through a registered output.
//
// Ports
//   clk             single clock for all logic
//   rst             asynchronous, active-high reset
//   wr_en           write strobe
//   wr_data         write word (WR_DATA_WIDTH)
//   flush           commit a partially packed word
//   wr_full         memory full, writes refused
//   almost_full     wr_water_level >= ALMOST_FULL_NUM
//   wr_water_level  occupancy in write words (committed*RATIO + lane_cnt)
//   rd_en           read strobe
//   rd_data         read word (WR_DATA_WIDTH*RATIO), registered
//   rd_empty        no committed read word
//   almost_empty    rd_water_level <= ALMOST_EMPTY_NUM
//   rd_water_level  committed read words
//   burst_rdy       rd_water_level >= BURST_LEN
//   overflow        sticky: a write was refused
//   underflow       sticky: a read was refused
// ---------------------------------------------------------------------------
module wr_ddr_pack_fifo #(
    parameter int WR_DATA_WIDTH    = 64,
    parameter int RATIO            = 4,
    parameter int RD_DEPTH_WIDTH   = 9,
    parameter int ALMOST_FULL_NUM  = 2040,
    parameter int ALMOST_EMPTY_NUM = 80,
    parameter int BURST_LEN        = 16,
    localparam int RD_DATA_WIDTH   = WR_DATA_WIDTH * RATIO,
    localparam int LW              = RD_DEPTH_WIDTH + $clog2(RATIO)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    input  logic                      flush,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [LW:0]               wr_water_level,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      burst_rdy,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int LOG2R  = $clog2(RATIO);
    localparam int LANE_W = (LOG2R > 0) ? LOG2R : 1;
    localparam int DEPTH  = 1 << RD_DEPTH_WIDTH;
    localparam logic [RD_DEPTH_WIDTH:0] DEPTH_CNT = (RD_DEPTH_WIDTH + 1)'(DEPTH);

    // Storage (no reset so it maps onto block RAM)
    logic [RD_DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [RD_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [RD_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [RD_DEPTH_WIDTH:0]   count_q, count_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [RD_DATA_WIDTH-1:0]  pack_q, pack_d;
    logic [RD_DATA_WIDTH-1:0]  rd_data_q;
    logic                      overflow_q, overflow_d;
    logic                      underflow_q, underflow_d;

    logic                      wr_accept;
    logic                      rd_accept;
    logic [RD_DATA_WIDTH-1:0]  word_d;
    logic [LANE_W:0]           lane_fill;
    logic                      commit_lane;
    logic                      commit_flush;
    logic                      commit;

    // Status from registered counters only (pre-edge state)
    assign wr_full        = (count_q == DEPTH_CNT);
    assign rd_empty       = (count_q == '0);
    assign rd_water_level = count_q;
    // lane_q is always zero when RATIO = 1, so the addition is harmless there
    assign wr_water_level = ((LW + 1)'(count_q) << LOG2R) + (LW + 1)'(lane_q);
    assign almost_full    = (32'(wr_water_level) >= ALMOST_FULL_NUM);
    assign almost_empty   = (32'(count_q) <= ALMOST_EMPTY_NUM);
    assign burst_rdy      = (32'(count_q) >= BURST_LEN);
    assign rd_data        = rd_data_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

    assign wr_accept = wr_en & ~wr_full;
    assign rd_accept = rd_en & ~rd_empty;

    // Packed word including a same-cycle accepted write in its lane
    always_comb begin
        word_d = pack_q;
        for (int i = 0; i < RATIO; i++) begin
            if (wr_accept && (lane_q == LANE_W'(i))) begin
                word_d[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
            end
        end
    end

    // Lanes occupied after this cycle's write; used to decide whether a
    // flush has anything to commit.
    assign lane_fill    = {1'b0, lane_q} + {{LANE_W{1'b0}}, wr_accept};
    assign commit_lane  = wr_accept && (lane_q == LANE_W'(RATIO - 1));
    assign commit_flush = (RATIO > 1) && flush && !wr_full && (lane_fill != '0);
    assign commit       = commit_lane | commit_flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        overflow_d  = overflow_q | (wr_en & wr_full);
        underflow_d = underflow_q | (rd_en & rd_empty);

        if (commit) begin
            wr_ptr_d = wr_ptr_q + RD_DEPTH_WIDTH'(1);
            lane_d   = '0;
            pack_d   = '0;
        end else begin
            lane_d   = lane_fill[LANE_W-1:0];
            pack_d   = word_d;
        end

        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + RD_DEPTH_WIDTH'(1);
        end

        // A commit and a read in the same cycle cancel out
        unique case ({commit, rd_accept})
            2'b10:   count_d = count_q + (RD_DEPTH_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (RD_DEPTH_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (rd_accept) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // A commit never targets a committed slot, so a same-cycle read of
    // rd_ptr_q always sees settled data.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[wr_ptr_q] <= word_d;
        end
    end

endmodule

// File: tb/tb_wr_ddr_pack_fifo.sv
module tb_wr_ddr_pack_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- default instance: 64-bit x4, depth 512 ----------------
    logic          wr_en0 = 1'b0;
    logic [63:0]   wr_data0 = '0;
    logic          flush0 = 1'b0;
    logic          rd_en0 = 1'b0;
    logic          wr_full0, almost_full0, rd_empty0, almost_empty0, burst_rdy0;
    logic          overflow0, underflow0;
    logic [11:0]   wr_level0;
    logic [9:0]    rd_level0;
    logic [255:0]  rd_data0;
    logic [6:0]    st0;

    assign st0 = {wr_full0, almost_full0, rd_empty0, almost_empty0, burst_rdy0, overflow0, underflow0};

    wr_ddr_pack_fifo dut0 (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en0),
        .wr_data        (wr_data0),
        .flush          (flush0),
        .wr_full        (wr_full0),
        .almost_full    (almost_full0),
        .wr_water_level (wr_level0),
        .rd_en          (rd_en0),
        .rd_data        (rd_data0),
        .rd_empty       (rd_empty0),
        .almost_empty   (almost_empty0),
        .rd_water_level (rd_level0),
        .burst_rdy      (burst_rdy0),
        .overflow       (overflow0),
        .underflow      (underflow0)
    );

    // ---------------- RATIO=1 instance: 16-bit, depth 16 ----------------
    logic          wr_en1 = 1'b0;
    logic [15:0]   wr_data1 = '0;
    logic          flush1 = 1'b0;
    logic          rd_en1 = 1'b0;
    logic          wr_full1, almost_full1, rd_empty1, almost_empty1, burst_rdy1;
    logic          overflow1, underflow1;
    logic [4:0]    wr_level1;
    logic [4:0]    rd_level1;
    logic [15:0]   rd_data1;

    wr_ddr_pack_fifo #(
        .WR_DATA_WIDTH    (16),
        .RATIO            (1),
        .RD_DEPTH_WIDTH   (4),
        .ALMOST_FULL_NUM  (14),
        .ALMOST_EMPTY_NUM (2),
        .BURST_LEN        (8)
    ) dut1 (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en1),
        .wr_data        (wr_data1),
        .flush          (flush1),
        .wr_full        (wr_full1),
        .almost_full    (almost_full1),
        .wr_water_level (wr_level1),
        .rd_en          (rd_en1),
        .rd_data        (rd_data1),
        .rd_empty       (rd_empty1),
        .almost_empty   (almost_empty1),
        .rd_water_level (rd_level1),
        .burst_rdy      (burst_rdy1),
        .overflow       (overflow1),
        .underflow      (underflow1)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr0(input logic [63:0] d);
        wr_en0 = 1'b1;
        wr_data0 = d;
        tick();
        wr_en0 = 1'b0;
    endtask

    task automatic rd0();
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (st0 !== 7'b0011000) begin
            n_fail++;
            $display("FAIL reset_status: got %b, expected %b", st0, 7'b0011000);
        end
        n_checks++;
        if (wr_level0 !== 12'd0 || rd_level0 !== 10'd0 || rd_data0 !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_levels: wr=%0d rd=%0d data=%h, expected 0/0/0", wr_level0, rd_level0, rd_data0);
        end
        $display("test_reset: status=%b", st0);
    endtask

    task automatic test_pack();
        logic [255:0] exp;
        do_reset();
        wr0(64'h1); wr0(64'h2); wr0(64'h3);
        n_checks++;
        if (wr_level0 !== 12'd3 || rd_level0 !== 10'd0) begin
            n_fail++;
            $display("FAIL pack_partial_level: wr=%0d rd=%0d, expected 3/0", wr_level0, rd_level0);
        end
        wr0(64'h4);
        n_checks++;
        if (wr_level0 !== 12'd4 || rd_level0 !== 10'd1 || rd_empty0 !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_commit_level: wr=%0d rd=%0d empty=%b, expected 4/1/0", wr_level0, rd_level0, rd_empty0);
        end
        rd0();
        exp = {64'h4, 64'h3, 64'h2, 64'h1};
        n_checks++;
        if (rd_data0 !== exp) begin
            n_fail++;
            $display("FAIL pack_read_data: got %h, expected %h", rd_data0, exp);
        end
        n_checks++;
        if (rd_level0 !== 10'd0 || rd_empty0 !== 1'b1) begin
            n_fail++;
            $display("FAIL pack_after_read: rd=%0d empty=%b, expected 0/1", rd_level0, rd_empty0);
        end
        $display("test_pack: read %h", rd_data0);
    endtask

    task automatic test_flush();
        logic [255:0] exp;
        do_reset();
        // flush with nothing packed is a no-op
        flush0 = 1'b1; tick(); flush0 = 1'b0;
        n_checks++;
        if (rd_level0 !== 10'd0 || wr_level0 !== 12'd0) begin
            n_fail++;
            $display("FAIL flush_empty_noop: rd=%0d wr=%0d, expected 0/0", rd_level0, wr_level0);
        end
        wr0(64'hA); wr0(64'hB);
        flush0 = 1'b1; tick(); flush0 = 1'b0;
        n_checks++;
        if (rd_level0 !== 10'd1 || wr_level0 !== 12'd4) begin
            n_fail++;
            $display("FAIL flush_commit_level: rd=%0d wr=%0d, expected 1/4", rd_level0, wr_level0);
        end
        rd0();
        exp = {64'h0, 64'h0, 64'hB, 64'hA};
        n_checks++;
        if (rd_data0 !== exp) begin
            n_fail++;
            $display("FAIL flush_read_data: got %h, expected %h", rd_data0, exp);
        end
        n_checks++;
        if (wr_level0 !== 12'd0) begin
            n_fail++;
            $display("FAIL flush_wr_level_after_read: got %0d, expected 0", wr_level0);
        end
        // flush together with a write counts that write
        wr_en0 = 1'b1; wr_data0 = 64'hC; flush0 = 1'b1;
        tick();
        wr_en0 = 1'b0; flush0 = 1'b0;
        n_checks++;
        if (rd_level0 !== 10'd1 || wr_level0 !== 12'd4) begin
            n_fail++;
            $display("FAIL flush_with_write_level: rd=%0d wr=%0d, expected 1/4", rd_level0, wr_level0);
        end
        rd0();
        exp = {64'h0, 64'h0, 64'h0, 64'hC};
        n_checks++;
        if (rd_data0 !== exp) begin
            n_fail++;
            $display("FAIL flush_with_write_data: got %h, expected %h", rd_data0, exp);
        end
        $display("test_flush: last read %h", rd_data0);
    endtask

    task automatic test_underflow_and_concurrent();
        logic [255:0] w0;
        logic [255:0] exp;
        do_reset();
        wr0(64'h11); wr0(64'h12); wr0(64'h13); wr0(64'h14);
        rd0();
        w0 = {64'h14, 64'h13, 64'h12, 64'h11};
        rd0();  // refused: empty
        n_checks++;
        if (underflow0 !== 1'b1 || rd_data0 !== w0) begin
            n_fail++;
            $display("FAIL underflow: uf=%b data=%h, expected 1/%h", underflow0, rd_data0, w0);
        end
        for (int i = 0; i < 20; i++) wr0(64'h100 + 64'(i));
        n_checks++;
        if (rd_level0 !== 10'd5) begin
            n_fail++;
            $display("FAIL level5: got %0d, expected 5", rd_level0);
        end
        for (int i = 20; i < 23; i++) wr0(64'h100 + 64'(i));
        wr_en0 = 1'b1; wr_data0 = 64'h117; rd_en0 = 1'b1;
        tick();
        wr_en0 = 1'b0; rd_en0 = 1'b0;
        exp = {64'h103, 64'h102, 64'h101, 64'h100};
        n_checks++;
        if (rd_level0 !== 10'd5 || wr_level0 !== 12'd20 || rd_data0 !== exp) begin
            n_fail++;
            $display("FAIL concurrent_commit_read: rd=%0d wr=%0d data=%h, expected 5/20/%h", rd_level0, wr_level0, rd_data0, exp);
        end
        n_checks++;
        if (underflow0 !== 1'b1 || overflow0 !== 1'b0) begin
            n_fail++;
            $display("FAIL sticky_flags: uf=%b of=%b, expected 1/0", underflow0, overflow0);
        end
        $display("test_underflow_and_concurrent: level=%0d", rd_level0);
    endtask

    task automatic test_full();
        logic [255:0] exp;
        do_reset();
        for (int i = 0; i < 2039; i++) wr0(64'(i));
        n_checks++;
        if (almost_full0 !== 1'b0 || wr_level0 !== 12'd2039) begin
            n_fail++;
            $display("FAIL almost_full_below: af=%b wr=%0d, expected 0/2039", almost_full0, wr_level0);
        end
        wr0(64'd2039);
        n_checks++;
        if (almost_full0 !== 1'b1 || wr_full0 !== 1'b0) begin
            n_fail++;
            $display("FAIL almost_full_at: af=%b full=%b, expected 1/0", almost_full0, wr_full0);
        end
        for (int i = 2040; i < 2048; i++) wr0(64'(i));
        n_checks++;
        if (st0 !== 7'b1100100 || rd_level0 !== 10'd512 || wr_level0 !== 12'd2048) begin
            n_fail++;
            $display("FAIL full_status: st=%b rd=%0d wr=%0d, expected 1100100/512/2048", st0, rd_level0, wr_level0);
        end
        // flush while full is ignored and is not an overflow
        flush0 = 1'b1; tick(); flush0 = 1'b0;
        n_checks++;
        if (overflow0 !== 1'b0 || rd_level0 !== 10'd512) begin
            n_fail++;
            $display("FAIL flush_while_full: of=%b rd=%0d, expected 0/512", overflow0, rd_level0);
        end
        // write on full with a concurrent read: write refused, read accepted
        wr_en0 = 1'b1; wr_data0 = 64'hDEAD; rd_en0 = 1'b1;
        tick();
        wr_en0 = 1'b0; rd_en0 = 1'b0;
        exp = {64'd3, 64'd2, 64'd1, 64'd0};
        n_checks++;
        if (overflow0 !== 1'b1 || wr_full0 !== 1'b0 || rd_level0 !== 10'd511 || wr_level0 !== 12'd2044) begin
            n_fail++;
            $display("FAIL overflow_refused: of=%b full=%b rd=%0d wr=%0d, expected 1/0/511/2044", overflow0, wr_full0, rd_level0, wr_level0);
        end
        n_checks++;
        if (rd_data0 !== exp) begin
            n_fail++;
            $display("FAIL drain_word0: got %h, expected %h", rd_data0, exp);
        end
        for (int k = 1; k < 512; k++) begin
            rd0();
            exp = {64'(4*k+3), 64'(4*k+2), 64'(4*k+1), 64'(4*k)};
            n_checks++;
            if (rd_data0 !== exp) begin
                n_fail++;
                $display("FAIL drain_word%0d: got %h, expected %h", k, rd_data0, exp);
            end
            if (k % 64 == 0) $display("test_full: read word %0d = %h", k, rd_data0);
        end
        n_checks++;
        if (st0 !== 7'b0011010 || rd_level0 !== 10'd0 || wr_level0 !== 12'd0) begin
            n_fail++;
            $display("FAIL drained_status: st=%b rd=%0d wr=%0d, expected 0011010/0/0", st0, rd_level0, wr_level0);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] exp;
        do_reset();
        for (int i = 0; i < 6; i++) wr0(64'h31 + 64'(i));
        rd0(); rd0();  // one good read, one underflow
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (st0 !== 7'b0011000 || rd_level0 !== 10'd0 || wr_level0 !== 12'd0 || rd_data0 !== 256'd0) begin
            n_fail++;
            $display("FAIL async_reset: st=%b rd=%0d wr=%0d data=%h, expected 0011000/0/0/0", st0, rd_level0, wr_level0, rd_data0);
        end
        #1 rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) wr0(64'h50 + 64'(i));
        n_checks++;
        if (rd_level0 !== 10'd1 || wr_level0 !== 12'd4) begin
            n_fail++;
            $display("FAIL reset_residue_level: rd=%0d wr=%0d, expected 1/4", rd_level0, wr_level0);
        end
        rd0();
        exp = {64'h53, 64'h52, 64'h51, 64'h50};
        n_checks++;
        if (rd_data0 !== exp || rd_empty0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_residue_data: got %h empty=%b, expected %h/1", rd_data0, rd_empty0, exp);
        end
        $display("test_reset_mid: read %h", rd_data0);
    endtask

    task automatic test_ratio1_wrap();
        logic [15:0] q[$];
        logic [15:0] exp;
        logic [15:0] v;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            v = 16'hA000 + 16'(i * 7);
            q.push_back(v);
            wr_en1 = 1'b1; wr_data1 = v; tick();
        end
        wr_en1 = 1'b0;
        n_checks++;
        if (rd_level1 !== 5'd10 || wr_level1 !== 5'd10 || burst_rdy1 !== 1'b1 || almost_empty1 !== 1'b0) begin
            n_fail++;
            $display("FAIL r1_fill: rd=%0d wr=%0d burst=%b ae=%b, expected 10/10/1/0", rd_level1, wr_level1, burst_rdy1, almost_empty1);
        end
        // writes, reads and (ignored) flush together, crossing the pointer wrap
        for (int i = 10; i < 40; i++) begin
            v = 16'hA000 + 16'(i * 7);
            exp = q.pop_front();
            q.push_back(v);
            wr_en1 = 1'b1; wr_data1 = v; rd_en1 = 1'b1; flush1 = 1'b1;
            tick();
            n_checks++;
            if (rd_data1 !== exp || rd_level1 !== 5'd10) begin
                n_fail++;
                $display("FAIL r1_pair%0d: data=%h level=%0d, expected %h/10", i, rd_data1, rd_level1, exp);
            end
            $display("test_ratio1_wrap: pair %0d read %h", i, rd_data1);
        end
        wr_en1 = 1'b0; flush1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp = q.pop_front();
            rd_en1 = 1'b1;
            tick();
            n_checks++;
            if (rd_data1 !== exp) begin
                n_fail++;
                $display("FAIL r1_drain%0d: got %h, expected %h", i, rd_data1, exp);
            end
        end
        rd_en1 = 1'b0;
        n_checks++;
        if (rd_empty1 !== 1'b1 || rd_level1 !== 5'd0 || overflow1 !== 1'b0 || underflow1 !== 1'b0) begin
            n_fail++;
            $display("FAIL r1_end: empty=%b rd=%0d of=%b uf=%b, expected 1/0/0/0", rd_empty1, rd_level1, overflow1, underflow1);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_pack();
        test_flush();
        test_underflow_and_concurrent();
        test_full();
        test_reset_mid();
        test_ratio1_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
